// File: rtl/spi_pkg.sv
// Shared types, defaults and edge-strobe helper for the SPI serial-clock engine.
// The optional stall input is enabled by defining SPI_SCLK_STALL_EN.
package spi_pkg;

    localparam int SPI_DIV_W = 8;
    localparam int SPI_CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        RUN,
        HOLD
    } spi_state_t;

    // {cpol, cpha}
    typedef logic [1:0] spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = 2'b00;
    localparam spi_mode_t SPI_MODE1 = 2'b01;
    localparam spi_mode_t SPI_MODE2 = 2'b10;
    localparam spi_mode_t SPI_MODE3 = 2'b11;

    // Returns {sample, shift} for an edge; odd edges are leading.
    function automatic logic [1:0] edge_stb(
        input logic cpha,
        input logic odd,
        input logic last
    );
        logic [1:0] r;
        if (cpha) r = {~odd, odd};
        else      r = {odd, ~odd & ~last};
        return r;
    endfunction

endpackage

// File: rtl/spi_half_period_cnt.sv
// Half-period divider: counts 0..limit, ticking on the terminal count.
// The limit is captured on load; the load cycle itself already counts.
module spi_half_period_cnt
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic             i_hold,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_lim;
    logic [DIV_W-1:0] w_lim;

    assign w_lim  = i_load ? i_div : r_lim;
    assign o_tick = !i_clear && !i_hold && (r_cnt == w_lim);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_lim <= '0;
        end else begin
            if (i_load)
                r_lim <= i_div;
            if (i_clear)
                r_cnt <= '0;
            else if (!i_hold)
                r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI SCLK burst engine: all four modes, sample/shift strobes, busy/done.
// Define SPI_SCLK_STALL_EN to add the stall input (freezes timing mid-burst).
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int DIV_W = SPI_DIV_W,
    parameter int CNT_W = SPI_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
`ifdef SPI_SCLK_STALL_EN
    input  logic             stall,
`endif
    input  logic [DIV_W-1:0] div,
    input  logic             cpol,
    input  logic             cpha,
    input  logic [CNT_W-1:0] nbits,
    output logic             sclk,
    output logic             sample_stb,
    output logic             shift_stb,
    output logic             busy,
    output logic             done
);

    spi_state_t       r_state, w_state_nxt;
    spi_mode_t        r_mode;
    logic [CNT_W-1:0] r_nbits;
    logic [CNT_W:0]   r_edge, w_edge_nxt;
    logic [CNT_W:0]   w_k;
    logic [CNT_W:0]   w_2n;
    logic             r_sclk, w_sclk_nxt;
    logic [1:0]       r_stb, w_stb_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             w_go;
    logic             w_clear;
    logic             w_hold;
    logic             w_tick;

    assign w_go    = en && start && (r_state == IDLE) && (nbits != '0);
    assign w_clear = !en || ((r_state == IDLE) && !w_go);
`ifdef SPI_SCLK_STALL_EN
    assign w_hold  = (r_state != IDLE) && stall;
`else
    assign w_hold  = 1'b0;
`endif

    assign w_k  = r_edge + 1'b1;
    assign w_2n = {r_nbits, 1'b0};

    spi_half_period_cnt #(
        .DIV_W (DIV_W)
    ) u_hp (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_clear),
        .i_load  (w_go),
        .i_hold  (w_hold),
        .i_div   (div),
        .o_tick  (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_sclk_nxt  = r_sclk;
        w_edge_nxt  = r_edge;
        w_stb_nxt   = 2'b00;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        if (!en) begin
            w_state_nxt = IDLE;
            w_sclk_nxt  = cpol;
            w_edge_nxt  = '0;
            w_busy_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    w_sclk_nxt = cpol;
                    w_edge_nxt = '0;
                    w_busy_nxt = 1'b0;
                    if (start && nbits == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (start) begin
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = SETUP;
                        // div=0: the accept cycle is the whole setup half-period
                        if (w_tick) begin
                            w_state_nxt = RUN;
                            w_sclk_nxt  = ~cpol;
                            w_edge_nxt  = 1;
                            w_stb_nxt   = edge_stb(cpha, 1'b1, 1'b0);
                        end
                    end
                end
                HOLD: begin
                    if (w_tick) begin
                        w_state_nxt = IDLE;
                        w_sclk_nxt  = r_mode[1];
                        w_edge_nxt  = '0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end
                end
                default: begin
                    if (w_tick) begin
                        w_sclk_nxt  = ~r_sclk;
                        w_edge_nxt  = w_k;
                        w_stb_nxt   = edge_stb(r_mode[0], w_k[0], w_k == w_2n);
                        w_state_nxt = (w_k == w_2n) ? HOLD : RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_mode  <= SPI_MODE0;
            r_nbits <= '0;
            r_edge  <= '0;
            r_sclk  <= 1'b0;
            r_stb   <= 2'b00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_go) begin
                r_mode  <= {cpol, cpha};
                r_nbits <= nbits;
            end
            r_state <= w_state_nxt;
            r_edge  <= w_edge_nxt;
            r_sclk  <= w_sclk_nxt;
            r_stb   <= w_stb_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign sclk       = r_sclk;
    assign sample_stb = r_stb[1];
    assign shift_stb  = r_stb[0];
    assign busy       = r_busy;
    assign done       = r_done;

endmodule
